// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and the opcode decoder:
// opcode values, FSM state encoding, instruction field positions and the
// stored form of a fetched instruction.
package instruction_fetch_unit_pkg;

  // Opcodes carried in instruction[31:24]
  localparam logic [7:0] OP_ADD   = 8'h00;
  localparam logic [7:0] OP_SUB   = 8'h01;
  localparam logic [7:0] OP_AND   = 8'h02;
  localparam logic [7:0] OP_OR    = 8'h03;
  localparam logic [7:0] OP_MOV   = 8'h04;
  localparam logic [7:0] OP_LOADI = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  // Instruction field bit positions
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 24;
  localparam int OFFSET_MSB = 23;
  localparam int OFFSET_LSB = 16;
  localparam int DEST_MSB   = 18;
  localparam int DEST_LSB   = 16;
  localparam int SRC1_MSB   = 10;
  localparam int SRC1_LSB   = 8;
  localparam int SRC2_MSB   = 2;
  localparam int SRC2_LSB   = 0;
  localparam int IMM_MSB    = 7;
  localparam int IMM_LSB    = 0;

  // Instruction register contents. DEST is the low 3 bits of OFFSET and SRC2
  // is the low 3 bits of IMMEDIATE, so only the distinct fields are stored;
  // instruction[15:11] feeds no output and is not kept.
  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] offset;
    logic [2:0] src1;
    logic [7:0] immediate;
  } instr_t;

  localparam instr_t INSTR_NONE = '{opcode: 8'd0, offset: 8'd0, src1: 3'd0, immediate: 8'd0};

  // Signed word offset converted to a byte displacement
  function automatic logic [31:0] offset_to_bytes(input logic [7:0] offset);
    return {{22{offset[7]}}, offset, 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Signal bundle between the fetch unit, instruction memory and the decode /
// execute stage. master = fetch unit, slave = memory plus downstream stage.
interface instruction_fetch_unit_if;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDRESS;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSYWAIT;
  logic        STALL;
  logic        JUMP;
  logic        BRANCH;
  logic        ZERO;
  logic [31:0] PC;
  logic        INSTR_VALID;
  logic [7:0]  OPCODE;
  logic [7:0]  OFFSET;
  logic [2:0]  DEST;
  logic [2:0]  SRC1;
  logic [2:0]  SRC2;
  logic [7:0]  IMMEDIATE;

  modport master (
    output IMEM_READ, IMEM_ADDRESS, PC, INSTR_VALID,
    output OPCODE, OFFSET, DEST, SRC1, SRC2, IMMEDIATE,
    input  IMEM_READDATA, IMEM_BUSYWAIT, STALL, JUMP, BRANCH, ZERO
  );

  modport slave (
    input  IMEM_READ, IMEM_ADDRESS, PC, INSTR_VALID,
    input  OPCODE, OFFSET, DEST, SRC1, SRC2, IMMEDIATE,
    output IMEM_READDATA, IMEM_BUSYWAIT, STALL, JUMP, BRANCH, ZERO
  );
endinterface

// File: rtl/instruction_fetch_unit_next_pc_calc.sv
// Next program counter: PC+4, or PC+4 plus the sign-extended word offset
// when the issued instruction takes its branch/jump. Wraps modulo 2^32.
module instruction_fetch_unit_next_pc_calc
  import instruction_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [7:0]  offset,
  input  logic        taken,
  output logic [31:0] next_pc
);

  logic [31:0] seq_pc_s;
  logic [31:0] target_s;

  assign seq_pc_s = pc + 32'd4;
  assign target_s = seq_pc_s + offset_to_bytes(offset);

  // Choose the branch target or the sequential address
  always_comb begin
    next_pc = seq_pc_s;
    if (taken) begin
      next_pc = target_s;
    end else begin
      next_pc = seq_pc_s;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch sequencer: IDLE -> FETCH (wait for memory) -> ISSUE
// (present fields until downstream releases STALL) -> FETCH at the next PC.
// Every output comes straight from a register.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
(
  input  logic                       CLK,
  input  logic                       RESET,
  instruction_fetch_unit_if.master   bus
);

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] pc_r;
  logic [31:0] pc_next_s;
  logic [31:0] target_pc_s;
  instr_t      ir_r;
  instr_t      ir_next_s;
  logic        taken_s;
  logic        imem_read_r;
  logic        instr_valid_r;

  // Only consumed in ISSUE, so the decoder flags are ignored elsewhere
  assign taken_s = bus.JUMP | (bus.BRANCH & bus.ZERO);

  instruction_fetch_unit_next_pc_calc u_next_pc (
    .pc      (pc_r),
    .offset  (ir_r.offset),
    .taken   (taken_s),
    .next_pc (target_pc_s)
  );

  // Next-state, next-PC and instruction register load/clear decisions.
  // The instruction register is cleared on leaving ISSUE so the field
  // outputs read zero whenever INSTR_VALID is low.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    ir_next_s    = ir_r;
    case (state_r)
      ST_IDLE: begin
        state_next_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (!bus.IMEM_BUSYWAIT) begin
          state_next_s        = ST_ISSUE;
          ir_next_s.opcode    = bus.IMEM_READDATA[OPCODE_MSB:OPCODE_LSB];
          ir_next_s.offset    = bus.IMEM_READDATA[OFFSET_MSB:OFFSET_LSB];
          ir_next_s.src1      = bus.IMEM_READDATA[SRC1_MSB:SRC1_LSB];
          ir_next_s.immediate = bus.IMEM_READDATA[IMM_MSB:IMM_LSB];
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_ISSUE: begin
        if (!bus.STALL) begin
          state_next_s = ST_FETCH;
          pc_next_s    = target_pc_s;
          ir_next_s    = INSTR_NONE;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        ir_next_s    = INSTR_NONE;
      end
    endcase
  end

  // State, PC, instruction register and registered handshake outputs
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_r       <= ST_IDLE;
      pc_r          <= 32'd0;
      ir_r          <= INSTR_NONE;
      imem_read_r   <= 1'b0;
      instr_valid_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      pc_r          <= pc_next_s;
      ir_r          <= ir_next_s;
      imem_read_r   <= (state_next_s == ST_FETCH);
      instr_valid_r <= (state_next_s == ST_ISSUE);
    end
  end

  assign bus.IMEM_READ    = imem_read_r;
  assign bus.IMEM_ADDRESS = pc_r;
  assign bus.PC           = pc_r;
  assign bus.INSTR_VALID  = instr_valid_r;
  assign bus.OPCODE       = ir_r.opcode;
  assign bus.OFFSET       = ir_r.offset;
  assign bus.DEST         = ir_r.offset[2:0];
  assign bus.SRC1         = ir_r.src1;
  assign bus.SRC2         = ir_r.immediate[2:0];
  assign bus.IMMEDIATE    = ir_r.immediate;

endmodule
